// File: rtl/sector_timer_bank.sv
// Rotating-sector dwell timer bank: synchronises the index and sector sensors, tracks the live sector,
// accumulates per-sector microsecond time and revolutions, and snapshots them into a readable shadow bank.
module sector_timer_bank #(
  parameter int unsigned N_SECT      = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned TW          = 32,
  parameter int unsigned PW          = 32,
  parameter int unsigned STALL_TICKS = 1000000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tick_1us,
  input  logic          i_sct1,
  input  logic          i_sct2,
  input  logic          i_sct_id_ready,
  input  logic [AW-1:0] i_sct_id_mcu,
  input  logic          i_ram_change,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [TW-1:0] o_rd_data,
  output logic          o_rd_valid,
  output logic [AW-1:0] o_cur_sector,
  output logic [PW-1:0] o_period_out,
  output logic          o_not_rotate
);

  localparam int unsigned SW = $clog2(STALL_TICKS + 1);

  // Per sensor: [0] meta flop, [1] synchronised level, [2] previous level
  logic [2:0]    r_s1, r_s2;
  logic          r_e1, r_e2;
  logic [AW-1:0] r_cur;
  logic [PW-1:0] r_period_live;
  logic [PW-1:0] r_period_out;
  logic [SW-1:0] r_stall_cnt;
  logic          r_not_rotate;
  logic [TW-1:0] r_acc    [N_SECT];
  logic [TW-1:0] r_shadow [N_SECT];
  logic [TW-1:0] r_rd_data;
  logic          r_rd_valid;

  logic [AW-1:0]     w_cur_nxt;
  logic              w_id_ok;
  logic [N_SECT-1:0] w_inc;
  logic [TW-1:0]     w_rd_mux;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_e1 <= 1'b0;
      r_e2 <= 1'b0;
    end else begin
      r_s1 <= {r_s1[1:0], i_sct1};
      r_s2 <= {r_s2[1:0], i_sct2};
      r_e1 <= r_s1[1] & ~r_s1[2];
      r_e2 <= r_s2[1] & ~r_s2[2];
    end
  end

  // Sector priority: index edge, then processor override, then sector step
  always_comb begin
    w_id_ok   = 32'(i_sct_id_mcu) < N_SECT;
    w_cur_nxt = r_cur;
    if (r_e1) begin
      w_cur_nxt = '0;
    end else if (i_sct_id_ready && w_id_ok) begin
      w_cur_nxt = i_sct_id_mcu;
    end else if (r_e2) begin
      w_cur_nxt = (r_cur == AW'(N_SECT - 1)) ? '0 : r_cur + AW'(1);
    end
  end

  always_comb begin
    w_inc    = '0;
    w_rd_mux = '0;
    for (int unsigned i = 0; i < N_SECT; i++) begin
      w_inc[i] = i_tick_1us && !r_not_rotate && (r_cur == AW'(i));
      if (i_rd_addr == AW'(i)) w_rd_mux = r_shadow[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur         <= '0;
      r_period_live <= '0;
      r_period_out  <= '0;
      r_stall_cnt   <= '0;
      r_not_rotate  <= 1'b0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_cur      <= w_cur_nxt;
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_data <= w_rd_mux;

      if (i_ram_change) begin
        r_period_out  <= r_period_live;
        r_period_live <= r_e1 ? PW'(1) : '0;
      end else if (r_e1 && (r_period_live != '1)) begin
        r_period_live <= r_period_live + PW'(1);
      end

      // Stall counter parks at STALL_TICKS; any sensor edge restarts it
      if (r_e1 || r_e2) begin
        r_stall_cnt  <= '0;
        r_not_rotate <= 1'b0;
      end else if (i_tick_1us && (r_stall_cnt != SW'(STALL_TICKS))) begin
        r_stall_cnt <= r_stall_cnt + SW'(1);
        if (r_stall_cnt == SW'(STALL_TICKS - 1)) r_not_rotate <= 1'b1;
      end
    end
  end

  // Live accumulators and shadow bank; a coincident tick lands in the freshly cleared frame
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < N_SECT; i++) begin
      if (i_rst) begin
        r_acc[i]    <= '0;
        r_shadow[i] <= '0;
      end else if (i_ram_change) begin
        r_shadow[i] <= r_acc[i];
        r_acc[i]    <= w_inc[i] ? TW'(1) : '0;
      end else if (w_inc[i] && (r_acc[i] != '1)) begin
        r_acc[i] <= r_acc[i] + TW'(1);
      end
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_cur_sector = r_cur;
  assign o_period_out = r_period_out;
  assign o_not_rotate = r_not_rotate;

endmodule

// File: tb/tb_sector_timer_bank.sv
// Bench for sector_timer_bank: directed scenarios plus random traffic, checked against a
// cycle-level behavioural model of the sector/time/stall rules.
module tb_sector_timer_bank;

  localparam int unsigned N_SECT      = 12;
  localparam int unsigned AW          = 4;
  localparam int unsigned TW          = 8;
  localparam int unsigned PW          = 16;
  localparam int unsigned STALL_TICKS = 400;
  localparam int unsigned MAXT        = (1 << TW) - 1;
  localparam longint      MAXP        = (longint'(1) << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0, sct1 = 1'b0, sct2 = 1'b0, ready = 1'b0, rc = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] id_mcu = '0, rd_addr = '0;
  logic [TW-1:0] rd_data;
  logic          rd_valid, not_rotate;
  logic [AW-1:0] cur_sector;
  logic [PW-1:0] period_out;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int unsigned m_acc [N_SECT];
  int unsigned m_shadow [N_SECT];
  longint      m_per, m_period_out;
  int unsigned m_cur, m_cnt, m_rd_data;
  bit          m_nr, m_rd_valid;
  bit [4:1]    h1, h2;

  sector_timer_bank #(
    .N_SECT(N_SECT), .AW(AW), .TW(TW), .PW(PW), .STALL_TICKS(STALL_TICKS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_tick_1us(tick), .i_sct1(sct1), .i_sct2(sct2),
    .i_sct_id_ready(ready), .i_sct_id_mcu(id_mcu), .i_ram_change(rc),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_cur_sector(cur_sector), .o_period_out(period_out), .o_not_rotate(not_rotate)
  );

  always #5 clk = ~clk;

  // Sensor edges take effect on the 4th rising edge counting the one that first samples the level high
  function automatic void model_edge();
    bit e1, e2, inc;
    int unsigned c;
    if (rst) begin
      foreach (m_acc[i]) begin m_acc[i] = 0; m_shadow[i] = 0; end
      m_per = 0; m_period_out = 0; m_cur = 0; m_cnt = 0; m_nr = 0;
      m_rd_data = 0; m_rd_valid = 0; h1 = '0; h2 = '0;
      return;
    end
    e1  = h1[3] & ~h1[4];
    e2  = h2[3] & ~h2[4];
    c   = m_cur;
    inc = tick && !m_nr;
    m_rd_valid = rd_en;
    if (rd_en) m_rd_data = (int'(rd_addr) < N_SECT) ? m_shadow[rd_addr] : 0;
    if (rc) begin
      m_shadow = m_acc;
      m_period_out = m_per;
      foreach (m_acc[i]) m_acc[i] = 0;
      m_per = 0;
    end
    if (inc && m_acc[c] < MAXT) m_acc[c]++;
    if (e1 && m_per < MAXP) m_per++;
    if (e1 || e2) begin
      m_cnt = 0; m_nr = 0;
    end else if (tick && m_cnt < STALL_TICKS) begin
      m_cnt++;
      if (m_cnt == STALL_TICKS) m_nr = 1;
    end
    if (e1) m_cur = 0;
    else if (ready && int'(id_mcu) < N_SECT) m_cur = id_mcu;
    else if (e2) m_cur = (m_cur + 1) % N_SECT;
    h1 = {h1[3:1], sct1};
    h2 = {h2[3:1], sct2};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tick = 0; ready = 0; rc = 0; rd_en = 0;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1; cycn(2); rst = 0;
  endtask

  task automatic pulse_sct1();
    sct1 = 1; cycn(2); sct1 = 0; cycn(3);
  endtask

  task automatic pulse_sct2();
    sct2 = 1; cycn(2); sct2 = 0; cycn(3);
  endtask

  task automatic set_sector(input int unsigned s);
    ready = 1; id_mcu = AW'(s); cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin tick = 1; cyc(); end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick = 1; rd_en = 1; rc = $urandom_range(0, 1); ready = 1; id_mcu = 4'd3; cyc();
    end
    rst = 0;
    n_checks++;
    if (cur_sector !== '0 || rd_valid !== 1'b0 || rd_data !== '0 || period_out !== '0 || not_rotate !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: cur=%0d rd_valid=%0d rd_data=%0d period=%0d nr=%0d, all required 0",
               cur_sector, rd_valid, rd_data, period_out, not_rotate);
    end
  endtask

  task automatic test_sector_walk();
    do_reset();
    for (int i = 0; i < 10; i++) pulse_sct2();
    n_checks++;
    if (cur_sector !== AW'(10) || int'(cur_sector) != m_cur) begin
      n_errors++; $display("FAIL walk10: got %0d required 10", cur_sector);
    end
    pulse_sct2(); pulse_sct2();
    n_checks++;
    if (cur_sector !== AW'(0)) begin
      n_errors++; $display("FAIL walk_wrap: got %0d required 0", cur_sector);
    end
  endtask

  task automatic test_index_override();
    set_sector(7);
    sct1 = 1; cycn(3);
    n_checks++;
    if (cur_sector !== AW'(7)) begin
      n_errors++; $display("FAIL index_early: got %0d required 7", cur_sector);
    end
    cyc(); sct1 = 0;
    n_checks++;
    if (cur_sector !== AW'(0)) begin
      n_errors++; $display("FAIL index_latency: got %0d required 0", cur_sector);
    end
    cycn(3);
    set_sector(5);
    n_checks++;
    if (cur_sector !== AW'(5)) begin
      n_errors++; $display("FAIL override5: got %0d required 5", cur_sector);
    end
    set_sector(13);
    n_checks++;
    if (cur_sector !== AW'(5)) begin
      n_errors++; $display("FAIL override_oob: got %0d required 5", cur_sector);
    end
    set_sector(11);
    pulse_sct2();
    n_checks++;
    if (cur_sector !== AW'(0)) begin
      n_errors++; $display("FAIL wrap_from_11: got %0d required 0", cur_sector);
    end
  endtask

  task automatic test_dwell();
    do_reset();
    pulse_sct1(); pulse_sct1();
    set_sector(3); ticks(250);
    set_sector(4); ticks(100);
    rc = 1; cyc();
    n_checks++;
    if (period_out !== PW'(2)) begin
      n_errors++; $display("FAIL period: got %0d required 2", period_out);
    end
    rd_en = 1; rd_addr = 4'd3; cyc();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== TW'(250)) begin
      n_errors++; $display("FAIL dwell3: got valid=%0d data=%0d required 1/250", rd_valid, rd_data);
    end
    rd_en = 1; rd_addr = 4'd4; cyc();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== TW'(100)) begin
      n_errors++; $display("FAIL dwell4: got valid=%0d data=%0d required 1/100", rd_valid, rd_data);
    end
    cyc();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== TW'(100)) begin
      n_errors++; $display("FAIL rd_idle: got valid=%0d data=%0d required 0/100", rd_valid, rd_data);
    end
    rc = 1; cyc();
    rd_en = 1; rd_addr = 4'd3; cyc();
    n_checks++;
    if (rd_data !== '0 || period_out !== '0) begin
      n_errors++; $display("FAIL live_cleared: got data=%0d period=%0d required 0/0", rd_data, period_out);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    set_sector(6); ticks(40);
    tick = 1; rc = 1; rd_en = 1; rd_addr = 4'd6; cyc();
    n_checks++;
    if (rd_data !== '0) begin
      n_errors++; $display("FAIL read_during_snap: got %0d required 0", rd_data);
    end
    rd_en = 1; rd_addr = 4'd6; cyc();
    n_checks++;
    if (rd_data !== TW'(40)) begin
      n_errors++; $display("FAIL snap_coincident: got %0d required 40", rd_data);
    end
    rc = 1; cyc();
    rd_en = 1; rd_addr = 4'd6; cyc();
    n_checks++;
    if (rd_data !== TW'(1)) begin
      n_errors++; $display("FAIL carry_tick: got %0d required 1", rd_data);
    end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    set_sector(2); ticks(STALL_TICKS - 1);
    n_checks++;
    if (not_rotate !== 1'b0) begin
      n_errors++; $display("FAIL stall_early: got %0d required 0", not_rotate);
    end
    ticks(1);
    n_checks++;
    if (not_rotate !== 1'b1) begin
      n_errors++; $display("FAIL stall_set: got %0d required 1", not_rotate);
    end
    ticks(20);
    rc = 1; cyc();
    rd_en = 1; rd_addr = 4'd2; cyc();
    n_checks++;
    if (rd_data !== TW'(MAXT) || period_out !== '0) begin
      n_errors++; $display("FAIL saturate: got data=%0d period=%0d required %0d/0", rd_data, period_out, MAXT);
    end
    rc = 1; tick = 1; cyc();
    ticks(10);
    sct2 = 1; cycn(3);
    n_checks++;
    if (not_rotate !== 1'b1) begin
      n_errors++; $display("FAIL stall_hold: got %0d required 1", not_rotate);
    end
    cyc(); sct2 = 0;
    n_checks++;
    if (not_rotate !== 1'b0 || cur_sector !== AW'(3)) begin
      n_errors++; $display("FAIL stall_clear: got nr=%0d cur=%0d required 0/3", not_rotate, cur_sector);
    end
    rc = 1; cyc();
    rd_en = 1; rd_addr = 4'd2; cyc();
    n_checks++;
    if (rd_data !== '0) begin
      n_errors++; $display("FAIL frozen_acc: got %0d required 0", rd_data);
    end
    rd_en = 1; rd_addr = 4'd15; cyc();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      n_errors++; $display("FAIL rd_oob: got valid=%0d data=%0d required 1/0", rd_valid, rd_data);
    end
  endtask

  task automatic test_random(input int n, input bit quiet_sensors);
    for (int i = 0; i < n; i++) begin
      if (!quiet_sensors && $urandom_range(0, 7) == 0) sct1 = ~sct1;
      if (!quiet_sensors && $urandom_range(0, 3) == 0) sct2 = ~sct2;
      if (quiet_sensors) begin sct1 = 0; sct2 = 0; end
      tick    = ($urandom_range(0, 1) == 0);
      ready   = ($urandom_range(0, 15) == 0);
      id_mcu  = AW'($urandom_range(0, 15));
      rc      = ($urandom_range(0, 63) == 0);
      rd_en   = ($urandom_range(0, 2) == 0);
      rd_addr = AW'($urandom_range(0, 15));
      cyc();
      n_checks++;
      if (int'(cur_sector) != m_cur || not_rotate !== m_nr || longint'(period_out) != m_period_out
          || rd_valid !== m_rd_valid || int'(rd_data) != m_rd_data) begin
        n_errors++;
        $display("FAIL random[%0d]: got cur=%0d nr=%0d per=%0d v=%0d d=%0d required cur=%0d nr=%0d per=%0d v=%0d d=%0d",
                 i, cur_sector, not_rotate, period_out, rd_valid, rd_data,
                 m_cur, m_nr, m_period_out, m_rd_valid, m_rd_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sector_walk();
    test_index_override();
    test_dwell();
    test_coincident();
    test_stall_saturate();
    do_reset();
    test_random(3000, 1'b0);
    test_random(1200, 1'b1);
    test_random(500, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sector_timer_bank.md
Name: sector_timer_bank

Overview:
Parametrised successor to the fixed 16-sector counter. Tracks the current rotating sector from index (sct1) and sector (sct2) pulses, with a processor override. Accumulates per-sector dwell time in microsecond ticks and counts revolutions. Everything runs in a single clock domain. On each ram_change, the block snapshots all counters into a shadow bank, and a processor/RAM writer reads that bank through an addressed read port.

Parameters:
N_SECT, 16, number of sectors (2..64, need not be a power of 2)
AW, 4, sector address width, ceil(log2(N_SECT))
TW, 32, per-sector time counter width
PW, 32, revolution counter width
STALL_TICKS, 1000000, tick_1us count with no sensor edge before not_rotate asserts

Ports:
clk  in  1  system clock, sole clock
rst  in  1  reset
tick_1us  in  1  one-clk strobe per microsecond, synchronous to clk
sct1  in  1  index sensor, asynchronous, marks sector 0
sct2  in  1  sector sensor, asynchronous, one pulse per sector boundary
sct_id_ready  in  1  one-clk strobe: sct_id_mcu valid
sct_id_mcu  in  AW  processor-computed sector id
ram_change  in  1  one-clk strobe: snapshot and clear frame
rd_en  in  1  shadow read request
rd_addr  in  AW  shadow sector index
rd_data  out  TW  shadow time for rd_addr
rd_valid  out  1  rd_data valid strobe
cur_sector  out  AW  live sector address
period_out  out  PW  revolutions in last completed frame (shadow)
not_rotate  out  1  rotation stalled flag

Behaviour:
- Reset: sync, active-high, on clk rising edge.
  - All live and shadow counters clear to 0.
  - cur_sector=0, period_out=0, rd_data=0, rd_valid=0, not_rotate=0.
  - Synchronizer flops clear to 0.
  - Reset asserted mid-frame discards all accumulated data.
- Sensor input conditioning:
  - sct1 and sct2 each pass through a 2-FF synchronizer, then a registered rising-edge detector producing e1 and e2 (one clk each).
  - Latency from the first clk that samples the input high to the edge pulse is 3 clk.
  - A level held high produces exactly one edge.
- Sector address update, highest priority first, evaluated per clk:
  1. e1: cur_sector<=0.
  2. sct_id_ready: cur_sector<=sct_id_mcu if sct_id_mcu<N_SECT; otherwise no change.
  3. e2: cur_sector<=cur_sector+1; N_SECT-1 wraps to 0.
- Live revolution count:
  - e1 increments live period count, saturating at 2^PW-1.
- Time accumulation:
  - On tick_1us with not_rotate=0, acc[cur_sector]+=1, saturating at 2^TW-1.
  - The increment uses the cur_sector value before this cycle's update.
  - Only one acc changes per clk.
- Frame snapshot on ram_change:
  - shadow[i]<=acc[i] for all i; period_out<=live period.
  - Live acc and live period clear the same clk.
  - If tick_1us, e1, or e2 coincide with ram_change, the snapshot holds the pre-event values. The event is applied to the cleared live state (e.g. acc[cur]=1 after a coincident tick).
  - cur_sector is unaffected by ram_change.
- Read port:
  - rd_en at cycle k gives rd_data=shadow[rd_addr] and rd_valid=1 at cycle k+1.
  - rd_valid=0 when rd_en is not asserted. rd_data holds its last value.
  - rd_addr>=N_SECT returns 0 with rd_valid=1.
  - A read coincident with ram_change returns the old shadow value.
- Stall detection:
  - Stall counter increments on tick_1us and clears to 0 on e1 or e2.
  - When the count reaches STALL_TICKS, not_rotate<=1 and the counter holds.
  - not_rotate<=0 on the clk after the next e1 or e2.
  - While not_rotate=1, acc does not increment. Period and sector logic still run.
  - ram_change does not clear the stall counter.

Test Plan:
- Reset, then 10 sct2 pulses with no sct1 → cur_sector=10. After 6 more pulses → cur_sector wraps to 0 (N_SECT=16).
- sct1 pulse at cur_sector=7 → cur_sector=0 3 clk later. sct_id_ready with sct_id_mcu=5 → cur_sector=5 next clk. sct_id_mcu=5 with N_SECT=12 and value 13 → no change.
- Hold sector 3 for 250 ticks and sector 4 for 100 ticks, with 2 sct1 pulses, then ram_change → read addr 3 → 250, addr 4 → 100, period_out=2; each rd_valid 1 clk after rd_en. Live acc is zero afterwards.
- tick_1us coincident with ram_change at acc[cur]=40 → shadow=40. Next snapshot of that sector includes the 1 coincident tick.
- STALL_TICKS=50, no sensor edges → not_rotate=1 exactly on the 50th tick. Further ticks leave acc unchanged. One sct2 pulse → not_rotate=0.
- TW=8, 300 ticks in one sector → shadow reads 255. rd_addr=15 with N_SECT=12 → rd_data=0, rd_valid=1.
